// File: rtl/gcd_csr_master_if.sv
// Signal bundle between the GCD CSR master, its streaming client and the Avalon-MM slave.
// The master modport is the block's own view; the slave modport is the surrounding fabric.
interface gcd_csr_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_gcd;
  logic        rsp_timeout;
  logic [2:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, avm_readdata, avm_waitrequest,
    output req_ready, rsp_valid, rsp_gcd, rsp_timeout,
           avm_address, avm_read, avm_write, avm_writedata
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, avm_readdata, avm_waitrequest,
    input  req_ready, rsp_valid, rsp_gcd, rsp_timeout,
           avm_address, avm_read, avm_write, avm_writedata
  );
endinterface

// File: rtl/gcd_csr_master.sv
// Avalon-MM master that loads an operand pair into the GCD CSR slave, polls its status
// until done, reads the result back and hands it to a valid/ready response port.
module gcd_csr_master #(
  parameter int POLL_LIMIT = 65535
) (
  input  logic clock,
  input  logic reset,
  gcd_csr_master_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, WR_A_LO, WR_A_HI, WR_B_LO, WR_B_HI,
    POLL_RD, POLL_WAIT, RD_LO, RD_LO_WAIT, RD_HI, RD_HI_WAIT, RESP
  } state_t;

  localparam logic [31:0] LIMIT = 32'(POLL_LIMIT);

  state_t      state;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_timeout;
  logic [63:0] rsp_gcd;
  logic [2:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] poll_cnt;
  logic [31:0] poll_next;
  logic [31:0] a_hi;
  logic [63:0] op_b;
  logic        accept;
  logic        zero_op;

  assign accept    = bus.req_valid && req_ready;
  assign zero_op   = (bus.req_a == 64'd0) || (bus.req_b == 64'd0);
  assign poll_next = poll_cnt + 32'd1;

  assign bus.req_ready     = req_ready;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_timeout   = rsp_timeout;
  assign bus.rsp_gcd       = rsp_gcd;
  assign bus.avm_address   = avm_address;
  assign bus.avm_read      = avm_read;
  assign bus.avm_write     = avm_write;
  assign bus.avm_writedata = avm_writedata;

  // Operand words still needed after the accept cycle; a[31:0] goes straight onto the bus.
  always_ff @(posedge clock) begin
    if (accept) begin
      a_hi <= bus.req_a[63:32];
      op_b <= bus.req_b;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_timeout   <= 1'b0;
      rsp_gcd       <= 64'd0;
      avm_address   <= 3'd0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'd0;
      poll_cnt      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            poll_cnt  <= 32'd0;
            req_ready <= 1'b0;
            // The slave never finishes with a zero operand, so answer locally.
            if (zero_op) begin
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_gcd     <= bus.req_a | bus.req_b;
            end else begin
              state         <= WR_A_LO;
              avm_write     <= 1'b1;
              avm_address   <= 3'd1;
              avm_writedata <= bus.req_a[31:0];
            end
          end
        end
        WR_A_LO: if (!bus.avm_waitrequest) begin
          state         <= WR_A_HI;
          avm_address   <= 3'd2;
          avm_writedata <= a_hi;
        end
        WR_A_HI: if (!bus.avm_waitrequest) begin
          state         <= WR_B_LO;
          avm_address   <= 3'd3;
          avm_writedata <= op_b[31:0];
        end
        WR_B_LO: if (!bus.avm_waitrequest) begin
          state         <= WR_B_HI;
          avm_address   <= 3'd4;
          avm_writedata <= op_b[63:32];
        end
        WR_B_HI: if (!bus.avm_waitrequest) begin
          state       <= POLL_RD;
          avm_write   <= 1'b0;
          avm_read    <= 1'b1;
          avm_address <= 3'd0;
        end
        POLL_RD: if (!bus.avm_waitrequest) begin
          state    <= POLL_WAIT;
          avm_read <= 1'b0;
        end
        POLL_WAIT: begin
          if (bus.avm_readdata == 32'd0) begin
            state       <= RD_LO;
            avm_read    <= 1'b1;
            avm_address <= 3'd1;
          end else begin
            poll_cnt <= poll_next;
            if (LIMIT != 32'd0 && poll_next == LIMIT) begin
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_gcd     <= 64'd0;
            end else begin
              state       <= POLL_RD;
              avm_read    <= 1'b1;
              avm_address <= 3'd0;
            end
          end
        end
        RD_LO: if (!bus.avm_waitrequest) begin
          state    <= RD_LO_WAIT;
          avm_read <= 1'b0;
        end
        RD_LO_WAIT: begin
          rsp_gcd[31:0] <= bus.avm_readdata;
          state         <= RD_HI;
          avm_read      <= 1'b1;
          avm_address   <= 3'd2;
        end
        RD_HI: if (!bus.avm_waitrequest) begin
          state    <= RD_HI_WAIT;
          avm_read <= 1'b0;
        end
        RD_HI_WAIT: begin
          rsp_gcd[63:32] <= bus.avm_readdata;
          state          <= RESP;
          rsp_valid      <= 1'b1;
          rsp_timeout    <= 1'b0;
        end
        RESP: if (bus.rsp_ready) begin
          state       <= IDLE;
          rsp_valid   <= 1'b0;
          rsp_timeout <= 1'b0;
          req_ready   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_csr_master.sv
// Bench for gcd_csr_master: a behavioural GCD CSR slave, directed jobs from the test plan
// and random jobs with random stalls, all checked against a plain-arithmetic GCD model.
module tb_gcd_csr_master;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  gcd_csr_master_if bus ();

  gcd_csr_master #(.POLL_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Bench-controlled knobs (written only by the stimulus block)
  bit stall_en = 1'b0;
  bit hang     = 1'b0;
  int busy_set = 2;

  // Slave model state and observation counters
  logic [31:0] sreg [0:7];
  int          busy_cnt = 0;
  bit          hang_busy = 1'b0;
  int          cyc = 0;
  int          polls = 0;
  int          reads = 0;
  int          strobes = 0;
  int          writes_while_busy = 0;
  int          hold_err = 0;
  logic [34:0] wlog [$];
  int          wcyc [$];

  function automatic logic [63:0] ref_gcd(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x = a;
    logic [63:0] y = b;
    logic [63:0] t;
    if (x == 0) return y;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [31:0] gcd_word(input logic [63:0] a, input logic [63:0] b, input bit hi);
    logic [63:0] r = ref_gcd(a, b);
    return hi ? r[63:32] : r[31:0];
  endfunction

  always @(negedge clock)
    bus.avm_waitrequest <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;

  // Behavioural slave: result lands in A, status stays busy for busy_set polls (or forever).
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset) begin
      busy_cnt  <= 0;
      hang_busy <= 1'b0;
    end else begin
      if (bus.avm_read || bus.avm_write) strobes <= strobes + 1;
      if (bus.avm_write && !bus.avm_waitrequest) begin
        wlog.push_back({bus.avm_address, bus.avm_writedata});
        wcyc.push_back(cyc);
        if (busy_cnt != 0 || hang_busy) writes_while_busy <= writes_while_busy + 1;
        else if (bus.avm_address == 3'd4) begin
          sreg[1]   <= gcd_word({sreg[2], sreg[1]}, {bus.avm_writedata, sreg[3]}, 1'b0);
          sreg[2]   <= gcd_word({sreg[2], sreg[1]}, {bus.avm_writedata, sreg[3]}, 1'b1);
          sreg[4]   <= bus.avm_writedata;
          busy_cnt  <= busy_set;
          hang_busy <= hang;
        end else sreg[bus.avm_address] <= bus.avm_writedata;
      end
      if (bus.avm_read && !bus.avm_waitrequest) begin
        reads <= reads + 1;
        if (bus.avm_address == 3'd0) begin
          polls <= polls + 1;
          bus.avm_readdata <= (busy_cnt != 0 || hang_busy) ? 32'd1 : 32'd0;
          if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        end else bus.avm_readdata <= sreg[bus.avm_address];
      end
    end
  end

  // Stalled strobe must repeat unchanged on the next cycle
  logic        p_stall = 1'b0;
  logic [2:0]  p_addr;
  logic [31:0] p_wdata;
  logic        p_rd, p_wr;
  always @(posedge clock) begin
    if (reset && p_stall &&
        (bus.avm_address !== p_addr || bus.avm_read !== p_rd || bus.avm_write !== p_wr ||
         (p_wr && bus.avm_writedata !== p_wdata)))
      hold_err <= hold_err + 1;
    p_stall <= reset && (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
    p_addr  <= bus.avm_address;
    p_wdata <= bus.avm_writedata;
    p_rd    <= bus.avm_read;
    p_wr    <= bus.avm_write;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one job, hold rsp_ready low for hold_cycles, then complete the handshake.
  task automatic run_job(input logic [63:0] a, input logic [63:0] b, input int hold_cycles,
                         input string tag, output logic [63:0] g, output logic to, output int lat);
    int n = 0;
    @(negedge clock);
    while (!bus.req_ready && n < 100) begin @(negedge clock); n++; end
    check({tag, " req_ready idle"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_a = a;
    bus.req_b = b;
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_a = {$urandom, $urandom};
    bus.req_b = {$urandom, $urandom};
    n = 0;
    while (!bus.rsp_valid && n < 2000) begin @(negedge clock); n++; end
    lat = n;
    check({tag, " rsp_valid arrives"}, 64'(bus.rsp_valid), 64'd1);
    g  = bus.rsp_gcd;
    to = bus.rsp_timeout;
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clock);
      check({tag, " hold valid"}, 64'(bus.rsp_valid), 64'd1);
      check({tag, " hold gcd"}, bus.rsp_gcd, g);
      check({tag, " hold req_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    check({tag, " post rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, " post req_ready"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] g, a, b, fac;
    logic        to;
    int          lat, w0, p0, s0, r0, n;

    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;

    // Reset values while reset is held low
    repeat (3) @(negedge clock);
    check("rst req_ready", 64'(bus.req_ready), 64'd1);
    check("rst strobes", {62'd0, bus.avm_read, bus.avm_write}, 64'd0);
    check("rst rsp", {62'd0, bus.rsp_valid, bus.rsp_timeout}, 64'd0);
    check("rst addr", 64'(bus.avm_address), 64'd0);
    check("rst wdata", 64'(bus.avm_writedata), 64'd0);
    check("rst gcd", bus.rsp_gcd, 64'd0);
    reset = 1'b1;

    // Basic job 48,18 without stalls
    w0 = wlog.size(); p0 = polls; r0 = reads; busy_set = 2;
    run_job(64'd48, 64'd18, 0, "basic", g, to, lat);
    check("basic gcd", g, 64'd6);
    check("basic timeout", 64'(to), 64'd0);
    check("basic nwrites", 64'(wlog.size() - w0), 64'd4);
    if (wlog.size() - w0 == 4) begin
      check("basic w0", 64'(wlog[w0]),   {29'd0, 3'd1, 32'd48});
      check("basic w1", 64'(wlog[w0+1]), {29'd0, 3'd2, 32'd0});
      check("basic w2", 64'(wlog[w0+2]), {29'd0, 3'd3, 32'd18});
      check("basic w3", 64'(wlog[w0+3]), {29'd0, 3'd4, 32'd0});
      check("basic consecutive", 64'(wcyc[w0+3] - wcyc[w0]), 64'd3);
    end
    check("basic polls", 64'(polls - p0), 64'd3);
    check("basic reads", 64'(reads - r0), 64'd5);

    // Upper-word operands
    w0 = wlog.size(); busy_set = 1;
    run_job(64'h0000_0003_0000_0000, 64'h0000_0001_8000_0000, 0, "upper", g, to, lat);
    check("upper gcd", g, 64'h0000_0001_8000_0000);
    if (wlog.size() - w0 == 4) begin
      check("upper w a_hi", 64'(wlog[w0+1]), {29'd0, 3'd2, 32'h3});
      check("upper w b_lo", 64'(wlog[w0+2]), {29'd0, 3'd3, 32'h8000_0000});
      check("upper w b_hi", 64'(wlog[w0+3]), {29'd0, 3'd4, 32'h1});
    end else check("upper nwrites", 64'(wlog.size() - w0), 64'd4);

    // Zero operands answered locally, one cycle after accept, bus untouched
    s0 = strobes;
    run_job(64'd0, 64'd35, 0, "zero_a", g, to, lat);
    check("zero_a gcd", g, 64'd35);
    check("zero_a latency", 64'(lat), 64'd0);
    run_job(64'd0, 64'd0, 0, "zero_ab", g, to, lat);
    check("zero_ab gcd", g, 64'd0);
    run_job(64'd77, 64'd0, 0, "zero_b", g, to, lat);
    check("zero_b gcd", g, 64'd77);
    check("zero no strobes", 64'(strobes - s0), 64'd0);

    // Random stalls plus response backpressure
    stall_en = 1'b1; busy_set = 3;
    run_job(64'd1071, 64'd462, 10, "stall", g, to, lat);
    check("stall gcd", g, 64'd21);
    check("stall timeout", 64'(to), 64'd0);

    // Random jobs, stalls on, random busy duration below the poll limit
    for (int k = 0; k < 6; k++) begin
      fac = 64'($urandom_range(1, 5000));
      a = fac * 64'($urandom_range(1, 32'h00FF_FFFF)) * 64'($urandom_range(1, 4000));
      b = fac * 64'($urandom_range(1, 32'h00FF_FFFF));
      busy_set = $urandom_range(1, 3);
      p0 = polls;
      run_job(a, b, $urandom_range(0, 3), "rand", g, to, lat);
      check("rand gcd", g, ref_gcd(a, b));
      check("rand timeout", 64'(to), 64'd0);
      check("rand polls", 64'(polls - p0), 64'(busy_set + 1));
    end
    stall_en = 1'b0;
    check("hold violations", 64'(hold_err), 64'd0);

    // Timeout: status never clears, POLL_LIMIT=4
    hang = 1'b1; p0 = polls;
    run_job(64'd10, 64'd4, 2, "timeout", g, to, lat);
    check("timeout flag", 64'(to), 64'd1);
    check("timeout gcd", g, 64'd0);
    check("timeout polls", 64'(polls - p0), 64'd4);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Reset while waiting on a poll read
    p0 = polls;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_a = 64'd99; bus.req_b = 64'd33;
    @(negedge clock);
    bus.req_valid = 1'b0;
    n = 0;
    while (polls == p0 && n < 100) begin @(negedge clock); n++; end
    check("midpoll reached", 64'(polls > p0), 64'd1);
    reset = 1'b0;
    #1;
    check("midpoll avm_read", 64'(bus.avm_read), 64'd0);
    check("midpoll rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midpoll req_ready async", 64'(bus.req_ready), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    hang = 1'b0; busy_set = 1;
    run_job(64'd12, 64'd8, 0, "after_rst", g, to, lat);
    check("after_rst gcd", g, 64'd4);
    check("after_rst timeout", 64'(to), 64'd0);
    check("writes while busy", 64'(writes_while_busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
